ex_mem_register: RTL and testbench
==================================

# ex_mem_register

EX/MEM pipeline register for the five-stage MIPS datapath. It sits directly downstream of the 32-bit ALU and captures `ALUResult`, `Zero`, store data and the memory/writeback control bits at each clock edge. It supports stall (hold) and flush (bubble), generates byte enables and lane-aligned store data for `sb`/`sh`/`sw`, and exposes the forwarding source for the EX stage.

## Interface
Parameters:
- `REG_ADDR_W`, 5: destination register index width.

Ports:
- `Clk` in 1: rising-edge clock.
- `Rst_n` in 1: synchronous, active-low reset.
- `Stall` in 1: hold all registered state.
- `Flush` in 1: load a bubble instead of EX contents.
- `EX_Valid` in 1: EX stage holds a real instruction.
- `EX_ALUResult` in 32: ALU output, which is also the memory address for loads and stores.
- `EX_Zero` in 1: ALU zero flag.
- `EX_StoreData` in 32: rt value for stores.
- `EX_WriteReg` in `REG_ADDR_W`: destination register.
- `EX_RegWrite`, `EX_MemRead`, `EX_MemWrite`, `EX_MemToReg` in 1 each: control bits.
- `EX_MemSize` in 2: 00 word, 01 half, 10 byte, 11 reserved (treated as word).
- `MEM_Valid` out 1; `MEM_ALUResult` out 32; `MEM_Zero` out 1; `MEM_WriteReg` out `REG_ADDR_W`.
- `MEM_RegWrite`, `MEM_MemRead`, `MEM_MemWrite`, `MEM_MemToReg`, `MEM_MemSize` out: registered controls.
- `MEM_StoreData` out 32: lane-aligned store data.
- `MEM_ByteEn` out 4: bit i enables `MEM_StoreData[8i+7:8i]`.
- `MEM_Misaligned` out 1: the held instruction was misaligned and its memory access was suppressed.
- `MEM_FwdValid` out 1: equals `MEM_Valid & MEM_RegWrite & (MEM_WriteReg != 0)`. This output is combinational from registered state.
- `MisalignCount` out 8: saturating count of misaligned accesses.

## Operation
- The register priority per edge is: `Rst_n`=0, then `Flush`, then `Stall`, then load.
- Reset:
  - Every registered output becomes 0, including `MEM_ByteEn`=4'b0000 and `MisalignCount`=0.
  - `MEM_FwdValid` is therefore 0.
- Flush:
  - Loads a bubble: `MEM_Valid`=0 and all controls, data, byte enables and `MEM_Misaligned` are 0.
  - Flush wins over a simultaneous `Stall`.
  - `MisalignCount` is unchanged.
- Stall (without Flush): every register, including `MisalignCount`, keeps its value.
- Load:
  - EX inputs are captured.
  - If `EX_Valid`=0, the block loads a bubble exactly as in Flush.
- Byte-enable generation for a valid load or store, with `a = EX_ALUResult[1:0]`:
  - Word: `ByteEn`=4'b1111. Misaligned if `a`!=0.
  - Half: `ByteEn`=4'b0011 if `a[1]`=0, else 4'b1100. Store data is `{2{EX_StoreData[15:0]}}`. Misaligned if `a[0]`=1.
  - Byte: `ByteEn`=`4'b0001 << a`. Store data is `{4{EX_StoreData[7:0]}}`. Never misaligned.
- For instructions that neither load nor store:
  - `ByteEn`=0.
  - `MEM_StoreData` = `EX_StoreData` unmodified.
- Misaligned access:
  - `MEM_MemRead`, `MEM_MemWrite` and `MEM_ByteEn` are forced to 0.
  - `MEM_Misaligned`=1.
  - `MEM_RegWrite` is forced to 0 for a misaligned load.
  - `MisalignCount` increments, saturating at 255.
- `MEM_ALUResult` and `MEM_Zero` always pass through unmodified on a valid load.

## Timing
- Latency is one cycle: EX values presented before edge N appear on MEM outputs after edge N.
- There is no combinational path from any EX input to any MEM output.
- `MEM_FwdValid` depends only on registered state.
- A stall lasts exactly as many cycles as `Stall` is high. The first edge with `Stall`=0 loads the current EX inputs.
- `MisalignCount` updates on the same edge that captures the misaligned instruction, and holds at 255.
- Reset applied mid-stall or mid-flush clears everything on that edge. The first load happens on the first edge with `Rst_n`=1.

## Configuration
- Macro: `EX_MEM_STORE_ALIGN_EN`.
- Defined: byte-enable generation, store-data replication, misalignment detection and `MisalignCount` operate as described above.
- Undefined:
  - `MEM_StoreData` = `EX_StoreData` unmodified.
  - `MEM_ByteEn` = 4'b1111 on any valid load or store, otherwise 0.
  - `MEM_Misaligned` is tied to 0 and `MisalignCount` is tied to 0.
  - `EX_MemSize` is still registered to `MEM_MemSize`.

## Test plan
- Reset and passthrough:
  - Stimulus: hold `Rst_n`=0 for 2 edges, then load an `add` with `ALUResult`=0x0000_0005, `WriteReg`=8, `RegWrite`=1.
  - Response: all outputs are 0 during reset; after the next edge `MEM_ALUResult`=5 and `MEM_FwdValid`=1.
- Stall, then flush:
  - Stimulus: load value X, raise `Stall` for 3 edges while the EX inputs change, then assert `Flush` and `Stall` together.
  - Response: outputs hold X for 3 cycles; after the flush edge `MEM_Valid`=0 and all controls are 0.
- Store byte:
  - Stimulus: `sb` with address 0x1003 and `StoreData`=0x0000_00AB.
  - Response: `MEM_ByteEn`=4'b1000, `MEM_StoreData`=0xABAB_ABAB.
- Store half:
  - Stimulus: `sh` with address 0x1002 and `StoreData`=0x1234_5678.
  - Response: `MEM_ByteEn`=4'b1100, `MEM_StoreData`=0x5678_5678.
- Misaligned accesses:
  - Stimulus: `lw` at 0x1001 with `RegWrite`=1, then `sh` at 0x1003.
  - Response: each cycle shows `MEM_Misaligned`=1, `MEM_MemRead`/`MEM_MemWrite`=0 and `MEM_RegWrite`=0; `MisalignCount` reads 1, then 2.
- Count saturation and `$zero` destination:
  - Stimulus: 260 consecutive misaligned `lw`, then a valid instruction with `WriteReg`=0 and `RegWrite`=1.
  - Response: `MisalignCount`=255; `MEM_FwdValid`=0.

Source files
------------

// File: rtl/ex_mem_register.sv
// ex_mem_register
//   EX/MEM pipeline register for the five-stage MIPS datapath. It captures the
//   ALU result, the zero flag, store data and the MEM/WB control bits on each
//   rising edge of Clk. It supports stall (hold) and flush (bubble), and it
//   exposes the forwarding-source qualifier for the EX stage.
//
//   Optional feature macro: EX_MEM_STORE_ALIGN_EN
//     defined   : byte-enable generation, store-data lane replication,
//                 misalignment detection and MisalignCount are active.
//     undefined : store data passes through unmodified, ByteEn is 4'b1111 for
//                 any valid load or store, and MEM_Misaligned and
//                 MisalignCount read 0.
//
// Ports
//   Clk, Rst_n         clock and synchronous active-low reset
//   Stall, Flush       hold / bubble (Flush wins over Stall)
//   EX_*               values coming from the EX stage
//   MEM_*              registered values seen by the MEM stage
//   MEM_FwdValid       MEM_Valid & MEM_RegWrite & (MEM_WriteReg != 0)
//   MisalignCount      saturating count of misaligned accesses
module ex_mem_register #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic                  EX_Valid,
  input  logic [31:0]           EX_ALUResult,
  input  logic                  EX_Zero,
  input  logic [31:0]           EX_StoreData,
  input  logic [REG_ADDR_W-1:0] EX_WriteReg,
  input  logic                  EX_RegWrite,
  input  logic                  EX_MemRead,
  input  logic                  EX_MemWrite,
  input  logic                  EX_MemToReg,
  input  logic [1:0]            EX_MemSize,
  output logic                  MEM_Valid,
  output logic [31:0]           MEM_ALUResult,
  output logic                  MEM_Zero,
  output logic [REG_ADDR_W-1:0] MEM_WriteReg,
  output logic                  MEM_RegWrite,
  output logic                  MEM_MemRead,
  output logic                  MEM_MemWrite,
  output logic                  MEM_MemToReg,
  output logic [1:0]            MEM_MemSize,
  output logic [31:0]           MEM_StoreData,
  output logic [3:0]            MEM_ByteEn,
  output logic                  MEM_Misaligned,
  output logic                  MEM_FwdValid,
  output logic [7:0]            MisalignCount
);

  logic        mem_access;
  logic [3:0]  byte_en_nxt;
  logic [31:0] store_data_nxt;
  logic        misaligned_nxt;
  logic        clear_stage;
  logic        load_stage;

  assign mem_access = EX_MemRead | EX_MemWrite;

  // Bubble on reset, flush, or a non-stalled edge with no real instruction.
  assign clear_stage = !Rst_n || Flush || (!Stall && !EX_Valid);
  assign load_stage  = !Stall && EX_Valid;

  always_comb begin
    byte_en_nxt    = 4'b0000;
    store_data_nxt = EX_StoreData;
    misaligned_nxt = 1'b0;
`ifdef EX_MEM_STORE_ALIGN_EN
    if (mem_access) begin
      unique case (EX_MemSize)
        2'b01: begin
          byte_en_nxt    = EX_ALUResult[1] ? 4'b1100 : 4'b0011;
          store_data_nxt = {2{EX_StoreData[15:0]}};
          misaligned_nxt = EX_ALUResult[0];
        end
        2'b10: begin
          byte_en_nxt    = 4'b0001 << EX_ALUResult[1:0];
          store_data_nxt = {4{EX_StoreData[7:0]}};
        end
        default: begin
          // Size 2'b11 is reserved and handled as a word access.
          byte_en_nxt    = 4'b1111;
          misaligned_nxt = |EX_ALUResult[1:0];
        end
      endcase
    end
`else
    if (mem_access) begin
      byte_en_nxt = 4'b1111;
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (clear_stage) begin
      MEM_Valid      <= 1'b0;
      MEM_ALUResult  <= 32'd0;
      MEM_Zero       <= 1'b0;
      MEM_WriteReg   <= '0;
      MEM_RegWrite   <= 1'b0;
      MEM_MemRead    <= 1'b0;
      MEM_MemWrite   <= 1'b0;
      MEM_MemToReg   <= 1'b0;
      MEM_MemSize    <= 2'b00;
      MEM_StoreData  <= 32'd0;
      MEM_ByteEn     <= 4'b0000;
      MEM_Misaligned <= 1'b0;
    end else if (load_stage) begin
      MEM_Valid      <= 1'b1;
      MEM_ALUResult  <= EX_ALUResult;
      MEM_Zero       <= EX_Zero;
      MEM_WriteReg   <= EX_WriteReg;
      // A misaligned load must not write back garbage.
      MEM_RegWrite   <= EX_RegWrite & ~(misaligned_nxt & EX_MemRead);
      MEM_MemRead    <= EX_MemRead & ~misaligned_nxt;
      MEM_MemWrite   <= EX_MemWrite & ~misaligned_nxt;
      MEM_MemToReg   <= EX_MemToReg;
      MEM_MemSize    <= EX_MemSize;
      MEM_StoreData  <= store_data_nxt;
      MEM_ByteEn     <= misaligned_nxt ? 4'b0000 : byte_en_nxt;
      MEM_Misaligned <= misaligned_nxt;
    end
  end

`ifdef EX_MEM_STORE_ALIGN_EN
  logic [7:0] misalign_cnt;

  // Flush leaves the count alone; only a captured misaligned access bumps it.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      misalign_cnt <= 8'd0;
    end else if (!Flush && load_stage && misaligned_nxt && (misalign_cnt != 8'hFF)) begin
      misalign_cnt <= misalign_cnt + 8'd1;
    end
  end

  assign MisalignCount = misalign_cnt;
`else
  assign MisalignCount = 8'd0;
`endif

  assign MEM_FwdValid = MEM_Valid & MEM_RegWrite & (MEM_WriteReg != '0);

endmodule

// File: tb/tb_ex_mem_register.sv
module tb_ex_mem_register;

`ifdef EX_MEM_STORE_ALIGN_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Rst_n, Stall, Flush, EX_Valid;
  logic [31:0] EX_ALUResult, EX_StoreData;
  logic        EX_Zero;
  logic [4:0]  EX_WriteReg;
  logic        EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg;
  logic [1:0]  EX_MemSize;
  logic        MEM_Valid, MEM_Zero, MEM_RegWrite, MEM_MemRead, MEM_MemWrite, MEM_MemToReg;
  logic [31:0] MEM_ALUResult, MEM_StoreData;
  logic [4:0]  MEM_WriteReg;
  logic [1:0]  MEM_MemSize;
  logic [3:0]  MEM_ByteEn;
  logic        MEM_Misaligned, MEM_FwdValid;
  logic [7:0]  MisalignCount;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  always #5 Clk = ~Clk;

  ex_mem_register #(.REG_ADDR_W(5)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Flush(Flush), .EX_Valid(EX_Valid),
    .EX_ALUResult(EX_ALUResult), .EX_Zero(EX_Zero), .EX_StoreData(EX_StoreData),
    .EX_WriteReg(EX_WriteReg), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
    .EX_MemWrite(EX_MemWrite), .EX_MemToReg(EX_MemToReg), .EX_MemSize(EX_MemSize),
    .MEM_Valid(MEM_Valid), .MEM_ALUResult(MEM_ALUResult), .MEM_Zero(MEM_Zero),
    .MEM_WriteReg(MEM_WriteReg), .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead),
    .MEM_MemWrite(MEM_MemWrite), .MEM_MemToReg(MEM_MemToReg), .MEM_MemSize(MEM_MemSize),
    .MEM_StoreData(MEM_StoreData), .MEM_ByteEn(MEM_ByteEn), .MEM_Misaligned(MEM_Misaligned),
    .MEM_FwdValid(MEM_FwdValid), .MisalignCount(MisalignCount)
  );

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic        zero;
    logic [31:0] sd;
    logic [4:0]  wr;
    logic        rw, mr, mw, m2r;
    logic [1:0]  sz;
    logic [3:0]  be;
    logic        mis;
  } exp_t;

  exp_t exp_q = '0;
  int   exp_cnt = 0;

  function automatic exp_t capture();
    exp_t e;
    int   a;
    bit   is_mem;
    e = '0;
    if (!EX_Valid) return e;
    e.valid = 1'b1;
    e.alu = EX_ALUResult;
    e.zero = EX_Zero;
    e.sd = EX_StoreData;
    e.wr = EX_WriteReg;
    e.rw = EX_RegWrite;
    e.mr = EX_MemRead;
    e.mw = EX_MemWrite;
    e.m2r = EX_MemToReg;
    e.sz = EX_MemSize;
    is_mem = EX_MemRead || EX_MemWrite;
    a = int'(EX_ALUResult % 4);
    if (is_mem && ALIGN) begin
      if (EX_MemSize == 2'd1) begin
        e.be  = (a >= 2) ? 4'd12 : 4'd3;
        e.sd  = (EX_StoreData % 32'h10000) * 32'h0001_0001;
        e.mis = (a % 2) != 0;
      end else if (EX_MemSize == 2'd2) begin
        e.be  = 4'(1 << a);
        e.sd  = (EX_StoreData % 32'h100) * 32'h0101_0101;
        e.mis = 1'b0;
      end else begin
        e.be  = 4'd15;
        e.mis = (a != 0);
      end
      if (e.mis) begin
        e.be = 4'd0;
        e.mr = 1'b0;
        e.mw = 1'b0;
        if (EX_MemRead) e.rw = 1'b0;
      end
    end else if (is_mem) begin
      e.be = 4'd15;
    end
    return e;
  endfunction

  always @(posedge Clk) begin
    if (!Rst_n) begin
      exp_q   <= '0;
      exp_cnt <= 0;
    end else if (Flush) begin
      exp_q <= '0;
    end else if (!Stall) begin
      exp_t e;
      e = capture();
      exp_q <= e;
      if (e.mis && exp_cnt < 255) exp_cnt <= exp_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Cycle-by-cycle compare against the model, away from the active edge.
  always @(negedge Clk) begin
    if (chk_en) begin
      check("valid",     32'(MEM_Valid),      32'(exp_q.valid));
      check("aluresult", MEM_ALUResult,       exp_q.alu);
      check("zero",      32'(MEM_Zero),       32'(exp_q.zero));
      check("storedata", MEM_StoreData,       exp_q.sd);
      check("writereg",  32'(MEM_WriteReg),   32'(exp_q.wr));
      check("regwrite",  32'(MEM_RegWrite),   32'(exp_q.rw));
      check("memread",   32'(MEM_MemRead),    32'(exp_q.mr));
      check("memwrite",  32'(MEM_MemWrite),   32'(exp_q.mw));
      check("memtoreg",  32'(MEM_MemToReg),   32'(exp_q.m2r));
      check("memsize",   32'(MEM_MemSize),    32'(exp_q.sz));
      check("byteen",    32'(MEM_ByteEn),     32'(exp_q.be));
      check("misaligned",32'(MEM_Misaligned), 32'(exp_q.mis));
      check("count",     32'(MisalignCount),  ALIGN ? 32'(exp_cnt) : 32'd0);
      check("fwdvalid",  32'(MEM_FwdValid),
            32'(exp_q.valid && exp_q.rw && (exp_q.wr != 5'd0)));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [4:0] wr, input logic rw, input logic mr,
                       input logic mw, input logic m2r, input logic [1:0] sz);
    EX_Valid = v; EX_ALUResult = alu; EX_StoreData = sd; EX_WriteReg = wr;
    EX_RegWrite = rw; EX_MemRead = mr; EX_MemWrite = mw; EX_MemToReg = m2r;
    EX_MemSize = sz; EX_Zero = (alu == 32'd0);
  endtask

  task automatic drive_random();
    drive(($urandom % 8) != 0, $urandom, $urandom, 5'($urandom), 1'($urandom),
          ($urandom % 3) == 0, ($urandom % 3) == 0, 1'($urandom), 2'($urandom));
    EX_Zero = 1'($urandom);
  endtask

  initial begin
    Rst_n = 1'b0; Stall = 1'b0; Flush = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 32'h1111_2222, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0);

    // Reset for two edges, with live-looking EX inputs.
    repeat (2) begin
      step();
      chk_en = 1'b1;
      check("rst_aluresult", MEM_ALUResult, 32'd0);
      check("rst_byteen", 32'(MEM_ByteEn), 32'd0);
      check("rst_count", 32'(MisalignCount), 32'd0);
      check("rst_fwd", 32'(MEM_FwdValid), 32'd0);
    end
    Rst_n = 1'b1;

    // add, result 5, rd = 8
    drive(1'b1, 32'h5, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    step();
    check("add_aluresult", MEM_ALUResult, 32'd5);
    check("add_fwd", 32'(MEM_FwdValid), 32'd1);

    // Stall holds X for three edges while EX changes, then flush+stall.
    drive(1'b1, 32'h77, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    step();
    Stall = 1'b1;
    repeat (3) begin
      drive_random();
      step();
      check("stall_aluresult", MEM_ALUResult, 32'h77);
      check("stall_valid", 32'(MEM_Valid), 32'd1);
    end
    Flush = 1'b1;
    step();
    check("flush_valid", 32'(MEM_Valid), 32'd0);
    check("flush_regwrite", 32'(MEM_RegWrite), 32'd0);
    check("flush_aluresult", MEM_ALUResult, 32'd0);
    Flush = 1'b0; Stall = 1'b0;

    // sb 0x1003
    drive(1'b1, 32'h1003, 32'h0000_00AB, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2);
    step();
    check("sb_byteen", 32'(MEM_ByteEn), ALIGN ? 32'h8 : 32'hF);
    check("sb_storedata", MEM_StoreData, ALIGN ? 32'hABAB_ABAB : 32'h0000_00AB);

    // sh 0x1002
    drive(1'b1, 32'h1002, 32'h1234_5678, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
    step();
    check("sh_byteen", 32'(MEM_ByteEn), ALIGN ? 32'hC : 32'hF);
    check("sh_storedata", MEM_StoreData, ALIGN ? 32'h5678_5678 : 32'h1234_5678);

    // Misaligned lw then sh
    drive(1'b1, 32'h1001, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0);
    step();
    check("lw_mis", 32'(MEM_Misaligned), 32'(ALIGN));
    check("lw_memread", 32'(MEM_MemRead), 32'(!ALIGN));
    check("lw_regwrite", 32'(MEM_RegWrite), 32'(!ALIGN));
    check("lw_count", 32'(MisalignCount), ALIGN ? 32'd1 : 32'd0);
    drive(1'b1, 32'h1003, 32'h55AA, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
    step();
    check("sh_mis", 32'(MEM_Misaligned), 32'(ALIGN));
    check("sh_memwrite", 32'(MEM_MemWrite), 32'(!ALIGN));
    check("sh_regwrite", 32'(MEM_RegWrite), 32'd0);
    check("sh_count", 32'(MisalignCount), ALIGN ? 32'd2 : 32'd0);

    // 260 misaligned lw saturate the count; then a $zero destination.
    drive(1'b1, 32'h1001, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0);
    repeat (260) step();
    check("sat_count", 32'(MisalignCount), ALIGN ? 32'd255 : 32'd0);
    drive(1'b1, 32'h42, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    step();
    check("zero_dest_fwd", 32'(MEM_FwdValid), 32'd0);
    check("zero_dest_valid", 32'(MEM_Valid), 32'd1);
    check("sat_hold", 32'(MisalignCount), ALIGN ? 32'd255 : 32'd0);

    // Randomized traffic with stalls, flushes and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      Stall = ($urandom % 6) == 0;
      Flush = ($urandom % 12) == 0;
      Rst_n = ($urandom % 150) != 0;
      step();
    end

    Rst_n = 1'b1; Stall = 1'b0; Flush = 1'b0;
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
